// File: rtl/pong_render_pipe.sv
// Pong render pipeline: VGA timing, frame-synchronous game-state shadows and a
// 3-stage pixel pipeline. Define PONG_GFX_FLASH_EN for the goal-flash border.
module pong_render_pipe #(
  parameter int          H_ACTIVE       = 640,
  parameter int          H_FP           = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BP           = 48,
  parameter int          V_ACTIVE       = 480,
  parameter int          V_FP           = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BP           = 33,
  parameter int          PAD_DISTANCE   = 16,
  parameter int          PAD_WIDTH      = 8,
  parameter int          PAD_HEIGHT     = 64,
  parameter int          BALL_SIZE_LOG2 = 4,
  parameter logic [7:0]  BG_LUM         = 8'h60,
  parameter int          FLASH_FRAMES   = 30
) (
  input  logic       clk_vga,
  input  logic       rst,
  input  logic [5:0] switch,
  input  logic [8:0] pad_left,
  input  logic [8:0] pad_right,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       goal_pulse,
  output logic       frame_start,
  output logic       VGA_BLANK_N,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int STAGES  = 3;
  localparam int N       = BALL_SIZE_LOG2;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] X_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0]   LP_X_LO  = 11'(PAD_DISTANCE);
  localparam logic [10:0]   LP_X_HI  = 11'(PAD_DISTANCE + PAD_WIDTH);
  localparam logic [10:0]   RP_X_LO  = 11'(H_ACTIVE - PAD_DISTANCE - PAD_WIDTH);
  localparam logic [10:0]   RP_X_HI  = 11'(H_ACTIVE - PAD_DISTANCE);
  localparam logic [10:0]   PAD_HALF = 11'(PAD_HEIGHT / 2);
  localparam logic [10:0]   BALL_LIM = 11'(1 << N);
  localparam logic [21:0]   DIST_LIM = 22'(1 << N);

  // ---------------------------------------------------------------- timing
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_end, v_end, latch;
  logic          act0, hs0, vs0;

  assign h_end = (hcnt == H_LAST);
  assign v_end = (vcnt == V_LAST);
  assign latch = (hcnt == '0) && (vcnt == V_ACT);
  assign frame_start = latch & ~rst;

  assign act0 = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs0  = !((hcnt >= HS_BEG) && (hcnt < HS_END));
  assign vs0  = !((vcnt >= VS_BEG) && (vcnt < VS_END));

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_end) begin
      hcnt <= '0;
      vcnt <= v_end ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Game state is only sampled at the start of vertical blanking, so a
  // frame never mixes old and new object positions.
  logic [8:0] sh_pad_l, sh_pad_r, sh_by;
  logic [9:0] sh_bx;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      sh_pad_l <= '0;
      sh_pad_r <= '0;
      sh_bx    <= '0;
      sh_by    <= '0;
    end else if (latch) begin
      sh_pad_l <= pad_left;
      sh_pad_r <= pad_right;
      sh_bx    <= ball_x;
      sh_by    <= ball_y;
    end
  end

  // ------------------------------------------------------- goal flash
  logic [7:0] border_lum;

`ifdef PONG_GFX_FLASH_EN
  localparam int FW = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_cnt;
  logic          unused_sw;

  always_ff @(posedge clk_vga) begin
    if (rst)
      flash_cnt <= '0;
    else if (goal_pulse)
      flash_cnt <= FW'(FLASH_FRAMES);
    else if (frame_start && (flash_cnt != '0))
      flash_cnt <= flash_cnt - 1'b1;
  end

  assign border_lum = ((flash_cnt != '0) && !flash_cnt[2]) ? 8'h00 : 8'hFF;
  assign unused_sw  = switch[5];
`else
  localparam int unused_flash_frames = FLASH_FRAMES;
  logic unused_in;
  assign border_lum = 8'hFF;
  assign unused_in  = ^{switch[5], goal_pulse};
`endif

  // --------------------------------------------- sync/valid shift registers
  logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vld_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], act0};
      hs_pipe  <= {hs_pipe[STAGES-1:1], hs0};
      vs_pipe  <= {vs_pipe[STAGES-1:1], vs0};
    end
  end

  // ---------------------------------------------------------- stage 1
  logic [HW-1:0] s1_x;
  logic [VW-1:0] s1_y;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s1_x <= '0;
      s1_y <= '0;
    end else begin
      s1_x <= hcnt;
      s1_y <= vcnt;
    end
  end

  // ---------------------------------------------------------- stage 2
  logic [10:0] x11, y11, bx11, by11, pl11, pr11, dx, dy;
  logic        frame2, pad2, far2;
  logic [21:0] dist2;
  logic [1:0]  chk2;

  always_comb begin
    x11    = 11'(s1_x);
    y11    = 11'(s1_y);
    bx11   = 11'(sh_bx);
    by11   = 11'(sh_by);
    pl11   = 11'(sh_pad_l);
    pr11   = 11'(sh_pad_r);
    frame2 = (s1_x == '0) || (s1_x == X_LAST) || (s1_y == '0) || (s1_y == Y_LAST);
    // pad extents are compared as y+half > centre so a pad near the top never underflows
    pad2   = ((x11 > LP_X_LO) && (x11 < LP_X_HI) &&
              ((y11 + PAD_HALF) > pl11) && (y11 < (pl11 + PAD_HALF))) ||
             ((x11 > RP_X_LO) && (x11 < RP_X_HI) &&
              ((y11 + PAD_HALF) > pr11) && (y11 < (pr11 + PAD_HALF)));
    dx     = (x11 > bx11) ? x11 - bx11 : bx11 - x11;
    dy     = (y11 > by11) ? y11 - by11 : by11 - y11;
    // large offsets must not square into a small (aliased) distance
    far2   = (dx >= BALL_LIM) || (dy >= BALL_LIM);
    dist2  = far2 ? '1 : (22'(dx) * 22'(dx)) + (22'(dy) * 22'(dy));
    chk2   = {s1_x[4] ^ s1_y[4], s1_x[1] ^ s1_y[1]};
  end

  logic        s2_frame, s2_pad;
  logic [21:0] s2_dist;
  logic [1:0]  s2_chk;

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      s2_frame <= 1'b0;
      s2_pad   <= 1'b0;
      s2_dist  <= '1;
      s2_chk   <= '0;
    end else begin
      s2_frame <= frame2;
      s2_pad   <= pad2;
      s2_dist  <= dist2;
      s2_chk   <= chk2;
    end
  end

  // ---------------------------------------------------------- stage 3
  logic [7:0]      ball_lum, f_lum, bg;
  logic [2:0][7:0] rgb3;
  logic [2:0][7:0] rgb_q;

  always_comb begin
    ball_lum = (s2_dist >= DIST_LIM) ? 8'h00 : 8'(~s2_dist[N-1:0]) << (8 - N);
    f_lum    = s2_pad ? 8'hFF : (s2_frame ? border_lum : ball_lum);
    bg       = ((switch[0] & s2_chk[0]) | (switch[1] & s2_chk[1])) ? BG_LUM : 8'h00;
    for (int c = 0; c < 3; c++)
      rgb3[c] = switch[2+c] ? (bg | f_lum) : f_lum;
  end

  always_ff @(posedge clk_vga) begin
    if (rst)
      rgb_q <= '0;
    else
      rgb_q <= vld_pipe[STAGES-1] ? rgb3 : '0;
  end

  assign VGA_BLANK_N = vld_pipe[STAGES];
  assign VGA_HS      = hs_pipe[STAGES];
  assign VGA_VS      = vs_pipe[STAGES];
  assign VGA_R       = rgb_q[0];
  assign VGA_G       = rgb_q[1];
  assign VGA_B       = rgb_q[2];

endmodule

// File: tb/tb_pong_render_pipe.sv
// Randomized bench for pong_render_pipe on a shrunken screen; a per-cycle
// reference model predicts every output from the rendering rules.
module tb_pong_render_pipe;
  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 48, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int PD = 4, PW = 4, PH = 8, NB = 4, FLASH = 6;
  localparam int BG = 8'h60;
  localparam int R2 = 1 << NB;
  localparam int NCYC = 9 * HT * VT;
  localparam int MIDRST = 5 * HT * VT + 37;
  localparam logic [26:0] RST_OUT = {1'b0, 1'b1, 1'b1, 24'h0};

  logic       clk_vga = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] switch = '0;
  logic [8:0] pad_left = '0, pad_right = '0, ball_y = '0;
  logic [9:0] ball_x = '0;
  logic       goal_pulse = 1'b0;
  logic       frame_start, VGA_BLANK_N, VGA_HS, VGA_VS;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  pong_render_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PAD_DISTANCE(PD), .PAD_WIDTH(PW), .PAD_HEIGHT(PH),
    .BALL_SIZE_LOG2(NB), .BG_LUM(8'h60), .FLASH_FRAMES(FLASH)
  ) dut (
    .clk_vga(clk_vga), .rst(rst), .switch(switch),
    .pad_left(pad_left), .pad_right(pad_right),
    .ball_x(ball_x), .ball_y(ball_y), .goal_pulse(goal_pulse),
    .frame_start(frame_start), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk_vga = ~clk_vga;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
  endtask

  // model state: current counter position, latched game state, flash count
  int mh = 0, mv = 0, s_pl = 0, s_pr = 0, s_bx = 0, s_by = 0, fc = 0;
  logic [26:0] dl [3];
  bit model_ok = 0;

  function automatic logic [26:0] pix(int x, int y);
    bit act, hs, vs, frm, pad;
    int dx, dy, d, lum, brd, fl, bg, v;
    logic [7:0] ch [3];
    act = (x < HA) && (y < VA);
    hs  = !((x >= HA + HF) && (x < HA + HF + HSY));
    vs  = !((y >= VA + VF) && (y < VA + VF + VSY));
    frm = (x == 0) || (x == HA - 1) || (y == 0) || (y == VA - 1);
    pad = ((x > PD) && (x < PD + PW) && (y > s_pl - PH / 2) && (y < s_pl + PH / 2)) ||
          ((x > HA - PD - PW) && (x < HA - PD) && (y > s_pr - PH / 2) && (y < s_pr + PH / 2));
    dx = (x > s_bx) ? x - s_bx : s_bx - x;
    dy = (y > s_by) ? y - s_by : s_by - y;
    lum = 0;
    if (dx < R2 && dy < R2) begin
      d = dx * dx + dy * dy;
      if (d < R2) lum = ((R2 - 1 - d) << (8 - NB)) & 255;
    end
    brd = 255;
`ifdef PONG_GFX_FLASH_EN
    if (fc != 0 && ((fc >> 2) & 1) == 0) brd = 0;
`endif
    fl = pad ? 255 : (frm ? brd : lum);
    bg = ((switch[0] && (((x ^ y) >> 1) & 1) != 0) ||
          (switch[1] && (((x ^ y) >> 4) & 1) != 0)) ? BG : 0;
    for (int c = 0; c < 3; c++) begin
      v = switch[2+c] ? (bg | fl) : fl;
      ch[c] = act ? 8'(v) : 8'h00;
    end
    return {act, hs, vs, ch[0], ch[1], ch[2]};
  endfunction

  // checker: compare, then advance the model across the coming clock edge
  initial begin
    bit latch;
    forever begin
      @(negedge clk_vga);
      if (model_ok) begin
        chk("frame_start", 32'(frame_start), 32'(!rst && mh == 0 && mv == VA));
        chk(rst ? "pix_rst" : "pix",
            32'({VGA_BLANK_N, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B}), 32'(dl[2]));
      end
      if (rst) begin
        mh = 0; mv = 0; s_pl = 0; s_pr = 0; s_bx = 0; s_by = 0; fc = 0;
        for (int i = 0; i < 3; i++) dl[i] = RST_OUT;
      end else begin
        dl[2] = dl[1];
        dl[1] = dl[0];
        dl[0] = pix(mh, mv);
        latch = (mh == 0) && (mv == VA);
        if (goal_pulse) fc = FLASH;
        else if (latch && fc > 0) fc--;
        if (latch) begin
          s_pl = int'(pad_left); s_pr = int'(pad_right);
          s_bx = int'(ball_x);   s_by = int'(ball_y);
        end
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else mh++;
      end
      model_ok = 1;
    end
  end

  task automatic new_objects();
    case ($urandom_range(0, 3))
      0:       ball_x = 10'd2;
      1:       ball_x = 10'(HA - 1 - $urandom_range(0, 3));
      default: ball_x = 10'($urandom_range(0, HA + 8));
    endcase
    ball_y    = 9'($urandom_range(0, VA + 4));
    pad_left  = 9'($urandom_range(0, VA + 4));
    pad_right = 9'($urandom_range(0, VA + 4));
  endtask

  initial begin
    int frames = 0;
    repeat (10) @(posedge clk_vga);
    #1 rst = 1'b0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk_vga);
      #1;
      goal_pulse = 1'b0;
      if (mh == 10 && mv == VA + 1) begin
        frames++;
        switch = 6'($urandom);
        if (frames % 4 == 2) goal_pulse = 1'b1;
      end
      // one update in vblank, another mid-frame that must not show until next frame
      if (mh == 20 && (mv == VA + 2 || mv == 20)) new_objects();
      if (cyc == MIDRST) rst = 1'b1;
      if (cyc == MIDRST + 3) rst = 1'b0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
